// File: rtl/pic_pkg.sv
// pic_pkg: shared constants and types for the PIC-style fetch path.
//   PC_WIDTH    - program-counter width (512-word program space)
//   STACK_DEPTH - hardware return-stack levels
//   RESET_VEC   - first fetch address after reset
//   LIT_W       - bits of PC loadable by CALL / PCL write; bits above are cleared
package pic_pkg;

    localparam int PC_WIDTH    = 9;
    localparam int STACK_DEPTH = 2;
    localparam int LIT_W       = 8;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t RESET_VEC = '1;

    // CALL targets and PCL writes only reach the low page: zero the upper bits.
    function automatic pc_t lit_ext(input logic [LIT_W-1:0] v);
        return pc_t'(v);
    endfunction

endpackage

// File: rtl/prog_counter_ret_stack.sv
// ret_stack: shift-register return stack.
//   clock, reset (async, active low)
//   push - shift entries down, load din at the top
//   pop  - shift entries up; the deepest entry is kept (duplicated)
//   din  - value pushed
//   top  - current top entry (stack[0])
//   lvl  - occupied levels, saturating at 0 and DEPTH
//   ovf  - sticky: push while full
//   unf  - sticky: pop while empty
module ret_stack
    import pic_pkg::*;
#(
    parameter int W     = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     top,
    output logic [LVL_W-1:0] lvl,
    output logic             ovf,
    output logic             unf
);

    logic [DEPTH-1:0][W-1:0] st;

    assign top = st[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st  <= '0;
            lvl <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            // Deepest entry falls off the end when full.
            for (int i = DEPTH - 1; i > 0; i--) st[i] <= st[i-1];
            st[0] <= din;
            if (lvl == LVL_W'(DEPTH)) ovf <= 1'b1;
            else                      lvl <= lvl + LVL_W'(1);
        end else if (pop) begin
            // st[DEPTH-1] is left alone, so it appears twice after the shift.
            for (int i = 0; i < DEPTH - 1; i++) st[i] <= st[i+1];
            if (lvl == '0) unf <= 1'b1;
            else           lvl <= lvl - LVL_W'(1);
        end
    end

endmodule

// File: rtl/prog_counter.sv
// prog_counter: program counter and fetch sequencer.
//   clock, reset (async, active low)
//   stall                         - freeze all state, suppress flush
//   goto_en/call_en/ret_en/pcl_we - control transfers (ret > call > goto > pcl)
//   skip_cond                     - skip next word (PC+1 with flush)
//   target, pcl_in                - jump literal / PCL data-bus value
//   pc_addr, pcl_out              - fetch address and its low byte
//   flush                         - combinational: discard word fetched this cycle
//   stack_lvl, stack_ovf, stack_unf - return-stack status
module prog_counter
    import pic_pkg::*;
#(
    parameter int                  PC_WIDTH    = pic_pkg::PC_WIDTH,
    parameter int                  STACK_DEPTH = pic_pkg::STACK_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_VEC   = '1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                goto_en,
    input  logic                call_en,
    input  logic                ret_en,
    input  logic                pcl_we,
    input  logic                skip_cond,
    input  logic [PC_WIDTH-1:0] target,
    input  logic [7:0]          pcl_in,
    output logic [PC_WIDTH-1:0] pc_addr,
    output logic [7:0]          pcl_out,
    output logic                flush,
    output logic [1:0]          stack_lvl,
    output logic                stack_ovf,
    output logic                stack_unf
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [PC_WIDTH-1:0] pc_nxt, stk_top;
    logic [LVL_W-1:0]    lvl;
    logic                push, pop;

    // While reset is low the control inputs are meaningless; keep flush quiet.
    assign flush = reset & ~stall & (ret_en | call_en | goto_en | pcl_we | skip_cond);

    assign pop  = ~stall & ret_en;
    assign push = ~stall & ~ret_en & call_en;

    always_comb begin
        pc_nxt = pc_addr + PC_WIDTH'(1);
        if (ret_en)       pc_nxt = stk_top;
        else if (call_en) pc_nxt = {{(PC_WIDTH-LIT_W){1'b0}}, target[LIT_W-1:0]};
        else if (goto_en) pc_nxt = target;
        else if (pcl_we)  pc_nxt = {{(PC_WIDTH-LIT_W){1'b0}}, pcl_in};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      pc_addr <= RESET_VEC;
        else if (!stall) pc_addr <= pc_nxt;
    end

    assign pcl_out   = pc_addr[7:0];
    assign stack_lvl = 2'(lvl);

    // The value pushed is the fetch address during the CALL, i.e. the word after it.
    ret_stack #(
        .W     (PC_WIDTH),
        .DEPTH (STACK_DEPTH),
        .LVL_W (LVL_W)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_addr),
        .top   (stk_top),
        .lvl   (lvl),
        .ovf   (stack_ovf),
        .unf   (stack_unf)
    );

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;
    import pic_pkg::*;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0, goto_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
    logic       pcl_we = 1'b0, skip_cond = 1'b0;
    pc_t        target = '0;
    logic [7:0] pcl_in = '0;
    pc_t        pc_addr;
    logic [7:0] pcl_out;
    logic       flush, stack_ovf, stack_unf;
    logic [1:0] stack_lvl;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: PC as an integer, stack as a queue of STACK_DEPTH entries.
    int m_pc, m_lvl;
    int m_stk[$];
    bit m_ovf, m_unf;

    prog_counter dut (
        .clock(clock), .reset(rst_n), .stall(stall), .goto_en(goto_en),
        .call_en(call_en), .ret_en(ret_en), .pcl_we(pcl_we), .skip_cond(skip_cond),
        .target(target), .pcl_in(pcl_in), .pc_addr(pc_addr), .pcl_out(pcl_out),
        .flush(flush), .stack_lvl(stack_lvl), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit exp_flush();
        return rst_n && !stall && (ret_en || call_en || goto_en || pcl_we || skip_cond);
    endfunction

    // Model update, priority ret > call > goto > pcl > sequential.
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 'h1FF; m_lvl = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
            for (int i = 0; i < STACK_DEPTH; i++) m_stk.push_back(0);
        end else if (!stall) begin
            if (ret_en) begin
                int top;
                top = m_stk[0];
                void'(m_stk.pop_front());
                m_stk.push_back(m_stk[$]);
                if (m_lvl == 0) m_unf = 1; else m_lvl--;
                m_pc = top;
            end else if (call_en) begin
                m_stk.push_front(m_pc);
                void'(m_stk.pop_back());
                if (m_lvl == STACK_DEPTH) m_ovf = 1; else m_lvl++;
                m_pc = target % 256;
            end else if (goto_en) m_pc = target;
            else if (pcl_we)      m_pc = pcl_in;
            else                  m_pc = (m_pc + 1) % 512;
        end
    end

    // Compare process: every cycle, mid-low-phase.
    always @(negedge clock) begin
        if (chk_en) begin
            #2;
            chk("pc_addr", pc_addr, m_pc);
            chk("pcl_out", pcl_out, m_pc % 256);
            chk("stack_lvl", stack_lvl, m_lvl);
            chk("stack_ovf", stack_ovf, m_ovf);
            chk("stack_unf", stack_unf, m_unf);
            chk("flush", flush, exp_flush());
        end
    end

    // Apply one cycle of inputs (called just after a negedge), return after next negedge.
    task automatic tick(input bit s, input bit g, input bit c, input bit r,
                        input bit p, input bit k, input int tgt, input int pin);
        stall = s; goto_en = g; call_en = c; ret_en = r; pcl_we = p; skip_cond = k;
        target = pc_t'(tgt); pcl_in = 8'(pin);
        #1;
        @(negedge clock);
        #3;
    endtask

    task automatic idle();     tick(0,0,0,0,0,0,0,0);   endtask
    task automatic go(int t);  tick(0,1,0,0,0,0,t,0);   endtask
    task automatic call(int t); tick(0,0,1,0,0,0,t,0);  endtask
    task automatic ret();      tick(0,0,0,1,0,0,0,0);   endtask

    initial begin
        // Reset with a control input active: flush must stay low.
        goto_en = 1'b1;
        #1;
        chk_en = 1'b1;
        #12;
        chk("rst_pc", pc_addr, 'h1FF);
        chk("rst_pcl", pcl_out, 'hFF);
        chk("rst_lvl", stack_lvl, 0);
        chk("rst_flags", {stack_ovf, stack_unf}, 0);
        chk("rst_flush", flush, 0);
        goto_en = 1'b0;
        @(negedge clock); rst_n = 1'b1; #3;
        chk("rel_pc", pc_addr, 'h1FF);
        idle(); chk("wrap0", pc_addr, 'h000);
        idle(); chk("wrap1", pc_addr, 'h001);
        idle(); chk("wrap2", pc_addr, 'h002);

        // GOTO and CALL from PC 0x010.
        go('h010); chk("goto010", pc_addr, 'h010);
        go('h1A5); chk("goto1A5", pc_addr, 'h1A5);
        go('h010);
        call('h1A5); chk("call_pc", pc_addr, 'h0A5); chk("call_lvl", stack_lvl, 1);
        ret();       chk("ret_pc", pc_addr, 'h010);  chk("ret_lvl", stack_lvl, 0);

        // Overflow then underflow.
        go('h020);
        call('h40); idle();
        call('h60); idle(); chk("pc061", pc_addr, 'h061);
        call('h80); chk("ovf_lvl", stack_lvl, 2); chk("ovf", stack_ovf, 1);
        ret(); chk("ret1", pc_addr, 'h061);
        ret(); chk("ret2", pc_addr, 'h041);
        chk("unf_before", stack_unf, 0);
        ret(); chk("ret3", pc_addr, 'h041); chk("unf", stack_unf, 1);
        chk("lvl_empty", stack_lvl, 0);

        // Skip and PCL write.
        go('h033);
        tick(0,0,0,0,0,1,0,0); chk("skip", pc_addr, 'h034);
        go('h1C0);
        tick(0,0,0,0,1,0,0,'hF0); chk("pcl_we", pc_addr, 'h0F0);

        // Stall with a pending GOTO.
        for (int i = 0; i < 4; i++) begin
            stall = 1'b1; goto_en = 1'b1; target = 'h155;
            #1; chk("stall_flush", flush, 0);
            @(negedge clock); #3;
            chk("stall_pc", pc_addr, 'h0F0);
        end
        go('h155); chk("unstall", pc_addr, 'h155);

        // Asynchronous reset during a CALL cycle (flags are set at this point).
        stall = 0; goto_en = 0; call_en = 1'b1; target = 'h077;
        #1; rst_n = 1'b0; #1;
        chk("ar_pc", pc_addr, 'h1FF);
        chk("ar_lvl", stack_lvl, 0);
        chk("ar_flags", {stack_ovf, stack_unf}, 0);
        chk("ar_flush", flush, 0);
        call_en = 1'b0;
        @(negedge clock); rst_n = 1'b1; #3;
        idle(); chk("after_ar", pc_addr, 'h000);

        // Randomized traffic, occasionally with several controls at once.
        for (int n = 0; n < 400; n++) begin
            int op;
            bit s, g, c, r, p, k;
            op = $urandom_range(0, 9);
            s = ($urandom_range(0, 7) == 0);
            r = (op == 0); c = (op == 1); g = (op == 2); p = (op == 3); k = (op == 4);
            if ($urandom_range(0, 5) == 0) begin
                r |= $urandom_range(0,1); c |= $urandom_range(0,1);
                g |= $urandom_range(0,1); p |= $urandom_range(0,1);
            end
            tick(s, g, c, r, p, k, $urandom_range(0, 511), $urandom_range(0, 255));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
